// File: rtl/pwm_ramp_sequencer.sv
// Shadow-register sequencer for a 16-bit PWM: applies period/compare updates only at PWM
// period boundaries and optionally ramps the compare value toward a target. Macro PWM_SEQ_IRQ_EN adds irq.
module pwm_ramp_sequencer #(
    parameter logic [15:0] DEFAULT_PERIOD  = 16'd1000,
    parameter logic [15:0] DEFAULT_COMPARE = 16'd0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  avs_address,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    output logic [15:0] period_out,
    output logic [15:0] comparison_value,
    output logic        busy
`ifdef PWM_SEQ_IRQ_EN
    ,
    output logic        irq
`endif
);

    // state  | meaning
    // IDLE   | nothing pending, outputs stable
    // ARMED  | update pending, waiting for the next period boundary
    // RAMP   | stepping comparison_value toward TARGET, one step per DIV boundaries
    // FINISH | one cycle: set DONE, re-arm if another update arrived
    typedef enum logic [1:0] {IDLE, ARMED, RAMP, FINISH} state_t;

    state_t      state;
    logic [15:0] mirror;
    logic [15:0] period_sh;
    logic [15:0] target_sh;
    logic [15:0] step_sh;
    logic [15:0] div_sh;
    logic [15:0] div_cnt;
    logic        ctrl_ramp_en;
    logic        ctrl_irq_en;
    logic        pend;
    logic        done;

    logic        boundary;
    logic        wr_pend;
    logic        wr_clear_done;
    logic [15:0] div_eff;
    logic [15:0] ramp_next;
    logic [16:0] cv_ext;
    logic [16:0] tgt_ext;
    logic [16:0] stp_ext;
    logic [31:0] rd_mux;
    logic        unused_wdata_hi;

    assign unused_wdata_hi = ^avs_writedata[31:16];

    assign boundary      = (mirror == period_out);
    assign wr_pend       = avs_write && (avs_address == 3'd1 || avs_address == 3'd2);
    assign wr_clear_done = avs_write && (avs_address == 3'd5) && avs_writedata[1];
    assign div_eff       = (div_sh == 16'd0) ? 16'd1 : div_sh;

    assign cv_ext  = {1'b0, comparison_value};
    assign tgt_ext = {1'b0, target_sh};
    assign stp_ext = {1'b0, step_sh};

    // 17-bit compares keep the step from overshooting or wrapping past TARGET
    always_comb begin
        ramp_next = target_sh;
        if (step_sh != 16'd0) begin
            if (tgt_ext > cv_ext) begin
                if (cv_ext + stp_ext < tgt_ext)
                    ramp_next = comparison_value + step_sh;
            end else begin
                if (cv_ext > tgt_ext + stp_ext)
                    ramp_next = comparison_value - step_sh;
            end
        end
    end

    always_comb begin
        rd_mux = 32'd0;
        case (avs_address)
            3'd0:    rd_mux = {30'd0, ctrl_irq_en, ctrl_ramp_en};
            3'd1:    rd_mux = {16'd0, period_sh};
            3'd2:    rd_mux = {16'd0, target_sh};
            3'd3:    rd_mux = {16'd0, step_sh};
            3'd4:    rd_mux = {16'd0, div_sh};
            3'd5:    rd_mux = {30'd0, done, busy};
            3'd6:    rd_mux = {16'd0, comparison_value};
            default: rd_mux = 32'd0;
        endcase
    end

`ifdef PWM_SEQ_IRQ_EN
    assign irq = done & ctrl_irq_en;
`else
    assign ctrl_irq_en = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            period_sh    <= DEFAULT_PERIOD;
            target_sh    <= DEFAULT_COMPARE;
            step_sh      <= 16'd1;
            div_sh       <= 16'd1;
            ctrl_ramp_en <= 1'b0;
`ifdef PWM_SEQ_IRQ_EN
            ctrl_irq_en  <= 1'b0;
`endif
            avs_readdata <= 32'd0;
        end else begin
            if (avs_write) begin
                case (avs_address)
                    3'd0: begin
                        ctrl_ramp_en <= avs_writedata[0];
`ifdef PWM_SEQ_IRQ_EN
                        ctrl_irq_en  <= avs_writedata[1];
`endif
                    end
                    3'd1:    period_sh <= avs_writedata[15:0];
                    3'd2:    target_sh <= avs_writedata[15:0];
                    3'd3:    step_sh   <= avs_writedata[15:0];
                    3'd4:    div_sh    <= avs_writedata[15:0];
                    default: ;
                endcase
            end
            if (avs_read)
                avs_readdata <= rd_mux;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            mirror           <= 16'd1;
            period_out       <= DEFAULT_PERIOD;
            comparison_value <= DEFAULT_COMPARE;
            busy             <= 1'b0;
            pend             <= 1'b0;
            done             <= 1'b0;
            div_cnt          <= 16'd1;
        end else begin
            mirror <= boundary ? 16'd1 : mirror + 16'd1;
            if (wr_clear_done)
                done <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (pend) begin
                        state <= ARMED;
                        busy  <= 1'b1;
                    end
                end
                ARMED: begin
                    if (boundary) begin
                        period_out <= period_sh;
                        pend       <= 1'b0;
                        div_cnt    <= 16'd1;
                        if (!ctrl_ramp_en || step_sh == 16'd0) begin
                            comparison_value <= target_sh;
                            state            <= FINISH;
                        end else begin
                            state <= RAMP;
                        end
                    end
                end
                RAMP: begin
                    if (boundary) begin
                        if (pend) begin
                            period_out <= period_sh;
                            pend       <= 1'b0;
                        end
                        if (comparison_value == target_sh) begin
                            state <= FINISH;
                        end else if (div_cnt >= div_eff) begin
                            div_cnt          <= 16'd1;
                            comparison_value <= ramp_next;
                            if (ramp_next == target_sh)
                                state <= FINISH;
                        end else begin
                            div_cnt <= div_cnt + 16'd1;
                        end
                    end
                end
                FINISH: begin
                    done  <= 1'b1;
                    busy  <= pend;
                    state <= pend ? ARMED : IDLE;
                end
                default: state <= IDLE;
            endcase
            // a register write landing on the same edge as a pend clear must survive
            if (wr_pend)
                pend <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Self-checking bench for pwm_ramp_sequencer: directed scenarios plus randomized ramps
// checked against an arithmetic model of the ramp sequence and its boundary timing.
module tb_pwm_ramp_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  avs_address;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic        avs_read;
    logic [31:0] avs_readdata;
    logic [15:0] period_out;
    logic [15:0] comparison_value;
    logic        busy;
`ifdef PWM_SEQ_IRQ_EN
    logic        irq;
`endif

    int checks = 0;
    int errors = 0;
    int cyc;
    int model_period;
    int model_cv;

    pwm_ramp_sequencer dut (
        .clock(clock),
        .reset(reset),
        .avs_address(avs_address),
        .avs_write(avs_write),
        .avs_writedata(avs_writedata),
        .avs_read(avs_read),
        .avs_readdata(avs_readdata),
        .period_out(period_out),
        .comparison_value(comparison_value),
        .busy(busy)
`ifdef PWM_SEQ_IRQ_EN
        ,
        .irq(irq)
`endif
    );

    always #5 clock = ~clock;

    // edges since reset release; PWM boundaries fall on multiples of the period
    always @(posedge clock or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input int d);
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        @(negedge clock);
        avs_write     = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        avs_address = a;
        avs_read    = 1'b1;
        @(negedge clock);
        avs_read    = 1'b0;
        d           = avs_readdata;
    endtask

    function automatic int next_val(input int cur, input int tgt, input int stp);
        if (stp == 0) return tgt;
        if (tgt > cur) return (cur + stp > tgt) ? tgt : cur + stp;
        return (cur - stp < tgt) ? tgt : cur - stp;
    endfunction

    task automatic run_ramp(input int per, input int tgt, input int stp, input int dv,
                            input int ctrl, input int rt_at, input int rt_to);
        int dve, t_exp, cur_m, tgt_m, budget, nsteps, diff, last_obs;
        bit jump, armed, changed, retgt;
        logic [31:0] d;
        dve     = (dv == 0) ? 1 : dv;
        jump    = ((ctrl & 1) == 0) || (stp == 0);
        t_exp   = -1;
        armed   = 0;
        changed = 0;
        retgt   = 0;
        cur_m   = model_cv;
        tgt_m   = tgt;
        last_obs = model_cv;
        diff    = (tgt > model_cv) ? tgt - model_cv : model_cv - tgt;
        nsteps  = jump ? 1 : diff / stp + 2;
        if (rt_at >= 0) nsteps += 4;
        budget  = model_period + 20 + (nsteps + 3) * dve * per;
        wr(3'd3, stp);
        wr(3'd4, dv);
        wr(3'd0, ctrl);
        wr(3'd1, per);
        wr(3'd2, tgt);
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            avs_write = 1'b0;
            if (!armed && period_out != model_period[15:0]) begin
                armed = 1;
                check("arm_period", period_out, per);
                t_exp = jump ? cyc : cyc + dve * per;
            end
            if (comparison_value != last_obs[15:0]) begin
                cur_m = next_val(cur_m, tgt_m, jump ? 0 : stp);
                check("ramp_value", comparison_value, cur_m);
                check("ramp_time", cyc, t_exp);
                last_obs = comparison_value;
                t_exp    = cyc + dve * per;
                changed  = 1;
                if (!retgt && cur_m == rt_at) begin
                    retgt         = 1;
                    tgt_m         = rt_to;
                    avs_address   = 3'd2;
                    avs_writedata = rt_to;
                    avs_write     = 1'b1;
                end
            end
            if (changed && cur_m == tgt_m && !busy) break;
        end
        avs_write = 1'b0;
        check("final_cv", comparison_value, tgt_m);
        check("final_busy", busy, 0);
        check("final_period", period_out, per);
        model_cv     = tgt_m;
        model_period = per;
        rd(3'd5, d);
        check("status_done", d, 2);
`ifdef PWM_SEQ_IRQ_EN
        check("irq_set", irq, (ctrl >> 1) & 1);
`endif
        wr(3'd5, 2);
`ifdef PWM_SEQ_IRQ_EN
        check("irq_clear", irq, 0);
`endif
        rd(3'd5, d);
        check("status_clear", d, 0);
    endtask

    initial begin
        logic [31:0] d;
        int per, tgt, stp, dv, ctrl;
        reset         = 1'b1;
        avs_address   = 3'd0;
        avs_write     = 1'b0;
        avs_writedata = 32'd0;
        avs_read      = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_period", period_out, 1000);
        check("rst_cv", comparison_value, 0);
        check("rst_busy", busy, 0);
        check("rst_rdata", avs_readdata, 0);
        reset = 1'b0;
        model_period = 1000;
        model_cv     = 0;

        repeat (3000) @(negedge clock);
        check("idle_period", period_out, 1000);
        check("idle_cv", comparison_value, 0);
        check("idle_busy", busy, 0);

        // update lands exactly on the 4th 1000-cycle boundary
        wr(3'd1, 10);
        wr(3'd2, 4);
        while (cyc < 3999) @(negedge clock);
        check("pre_bnd_period", period_out, 1000);
        check("pre_bnd_cv", comparison_value, 0);
        @(negedge clock);
        check("bnd_cyc", cyc, 4000);
        check("bnd_period", period_out, 10);
        check("bnd_cv", comparison_value, 4);
        model_period = 10;
        model_cv     = 4;
        repeat (3) @(negedge clock);
        rd(3'd5, d);
        check("jump_done", d, 2);
        wr(3'd5, 2);

        run_ramp(12, 0, 0, 1, 0, -1, 0);
        run_ramp(8, 10, 3, 2, 1, -1, 0);
        run_ramp(6, 0, 4, 1, 1, -1, 0);
        run_ramp(9, 12, 3, 1, 1, 6, 5);
        run_ramp(7, 20, 5, 1, 3, -1, 0);

        rd(3'd0, d);
`ifdef PWM_SEQ_IRQ_EN
        check("ctrl_read", d, 3);
`else
        check("ctrl_read", d, 1);
`endif
        rd(3'd6, d);
        check("current_read", d, model_cv);
        @(negedge clock);
        check("rdata_hold", avs_readdata, model_cv);
        wr(3'd7, 16'h1234);
        rd(3'd7, d);
        check("addr7_read", d, 0);
        rd(3'd1, d);
        check("period_shadow", d, 7);

        // reset in the middle of a ramp
        run_ramp(11, 0, 0, 1, 0, -1, 0);
        wr(3'd3, 3);
        wr(3'd4, 1);
        wr(3'd0, 1);
        wr(3'd1, 8);
        wr(3'd2, 30);
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (comparison_value == 16'd6) break;
        end
        check("mid_ramp_cv", comparison_value, 6);
        reset = 1'b1;
        #1;
        check("mid_rst_period", period_out, 1000);
        check("mid_rst_cv", comparison_value, 0);
        check("mid_rst_busy", busy, 0);
        @(negedge clock);
        reset = 1'b0;
        model_period = 1000;
        model_cv     = 0;
        rd(3'd1, d);
        check("rst_period_sh", d, 1000);
        rd(3'd3, d);
        check("rst_step_sh", d, 1);
        rd(3'd4, d);
        check("rst_div_sh", d, 1);
        rd(3'd0, d);
        check("rst_ctrl", d, 0);
        wr(3'd2, 7);
        while (cyc < 999) @(negedge clock);
        check("mirror_pre_cv", comparison_value, 0);
        @(negedge clock);
        check("mirror_cyc", cyc, 1000);
        check("mirror_cv", comparison_value, 7);
        model_cv = 7;
        repeat (3) @(negedge clock);
        wr(3'd5, 2);

        for (int k = 0; k < 6; k++) begin
            per = $urandom_range(20, 5);
            if (per == model_period) per = per + 1;
            tgt = $urandom_range(300, 0);
            if (tgt == model_cv) tgt = tgt + 1;
            stp  = ($urandom_range(4, 0) == 0) ? 0 : $urandom_range(40, 8);
            dv   = $urandom_range(3, 0);
            ctrl = $urandom_range(3, 0);
            run_ramp(per, tgt, stp, dv, ctrl, -1, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
